rst_module: RTL and testbench
=============================

RST_MODULE -- requirements
Module: rst_module

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the i_locked synchronizer (legal >= 2).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before reset release (legal >= 1).
REQ-003 SHALL have parameter PERIPH_DELAY, default 16: cycles between core and peripheral reset release (legal >= 1).
REQ-004 SHALL have parameter SW_RST_CYCLES, default 8: reset pulse length for a software reset (legal >= 1).
REQ-005 SHALL have port i_clk, input, 1: system clock (the 50 MHz MMCM output after BUFG); one clock domain only.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous to i_clk, active-high.
REQ-007 SHALL have port i_locked, input, 1: MMCM LOCKED, asynchronous to i_clk.
REQ-008 SHALL have port i_sw_rst, input, 1: software reset request, synchronous, level-sampled.
REQ-009 SHALL have port o_rst_core, output, 1: core reset, active-high.
REQ-010 SHALL have port o_rst_periph, output, 1: peripheral reset, active-high.
REQ-011 SHALL have port o_ready, output, 1: high only when both resets are released.
REQ-012 SHALL have port o_loss_cnt, output, 8: saturating count of lock-loss events.

Function
REQ-013 SHALL pass i_locked through a SYNC_STAGES flip-flop chain; lk_s is the last stage, and all state-machine decisions SHALL use lk_s only.
REQ-014 SHALL implement the states WAIT_LOCK, STABLE, REL_CORE, RUN and SWRST, with a single registered state and all outputs decoded from registered state (Moore).
REQ-015 In WAIT_LOCK and STABLE, o_rst_core=1 and o_rst_periph=1; in REL_CORE, o_rst_core=0 and o_rst_periph=1; in RUN, both =0; in SWRST, both =1.
REQ-016 o_ready SHALL equal 1 in RUN only.
REQ-017 WAIT_LOCK: lk_s=1 -> STABLE with counter=0; otherwise remain.
REQ-018 STABLE: lk_s=0 -> WAIT_LOCK with counter cleared; counter==LOCK_STABLE_CYCLES-1 -> REL_CORE with counter=0; otherwise counter+1.
REQ-019 REL_CORE: counter==PERIPH_DELAY-1 -> RUN; otherwise counter+1.
REQ-020 RUN: i_sw_rst=1 -> SWRST with counter=0; otherwise remain.
REQ-021 SWRST: counter==SW_RST_CYCLES-1 -> REL_CORE with counter=0, skipping STABLE; otherwise counter+1.
REQ-022 In REL_CORE, RUN or SWRST, lk_s=0 SHALL force WAIT_LOCK on the next edge and increment o_loss_cnt, saturating at 255; this SHALL take priority over i_sw_rst and over counter completion.
REQ-023 Lock loss in STABLE SHALL NOT increment o_loss_cnt.
REQ-024 i_sw_rst SHALL be ignored in every state except RUN; a level held high SHALL retrigger SWRST each time RUN is re-entered.
REQ-025 The shared counter SHALL be wide enough for max(LOCK_STABLE_CYCLES, PERIPH_DELAY, SW_RST_CYCLES)-1, and SHALL never wrap.
REQ-026 From the first edge that samples i_locked=1, with lk_s staying high, o_rst_core SHALL fall after exactly SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges.
REQ-027 o_rst_periph and o_ready SHALL change exactly PERIPH_DELAY edges after o_rst_core falls.
REQ-028 Reset assertion on lock loss SHALL take SYNC_STAGES+1 edges after i_locked falls; the assertion itself is synchronous.

Reset
REQ-029 i_rst=1 SHALL, on the next edge, force WAIT_LOCK, counter=0, o_loss_cnt=0 and all synchronizer flops=0; this SHALL take precedence over all other inputs.
REQ-030 While and after i_rst is high: o_rst_core=1, o_rst_periph=1, o_ready=0, o_loss_cnt=0.
REQ-031 i_rst asserted mid-sequence (any state) SHALL restart from WAIT_LOCK with no partial release.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, PERIPH_DELAY=4, SW_RST_CYCLES=3)
REQ-032 Power-up: i_rst for 3 cycles, then i_locked=1 held from edge 1 -> o_rst_core falls after edge 11, o_rst_periph and o_ready change after edge 15, o_loss_cnt=0.
REQ-033 Glitch: i_locked high for 5 cycles, low for 1, then high -> no release until 11 edges after the second rise; o_loss_cnt stays 0.
REQ-034 Lock loss in RUN: drop i_locked -> both resets =1 and o_ready=0 within 3 edges, o_loss_cnt=1; relock -> full 11+4 release sequence.
REQ-035 Software reset: 1-cycle i_sw_rst in RUN -> both resets high for 3 cycles, then o_rst_core low for 4 cycles before RUN; o_loss_cnt unchanged.
REQ-036 Priority: i_sw_rst=1 in the same cycle lk_s falls -> WAIT_LOCK (not SWRST) and o_loss_cnt increments.
REQ-037 Saturation: 260 lock-loss events from RUN -> o_loss_cnt=255; then i_rst -> o_loss_cnt=0.

Source files
------------

// File: rtl/rst_module.sv
// rtl/rst_module.sv - lock-qualified core/peripheral reset sequencer with software reset
//
// Purpose: holds core and peripheral logic in reset until the MMCM lock has
// been stable for LOCK_STABLE_CYCLES. It then releases the core reset, and
// releases the peripheral reset PERIPH_DELAY cycles later. A software request
// in RUN pulses both resets for SW_RST_CYCLES. Any later lock loss drops
// straight back to reset and bumps a saturating loss counter.
//
// Ports:
//   i_clk        system clock (single domain)
//   i_rst        synchronous active-high reset
//   i_locked     MMCM LOCKED, asynchronous, synchronized internally
//   i_sw_rst     software reset request, level-sampled, honoured only in RUN
//   o_rst_core   core reset, active-high
//   o_rst_periph peripheral reset, active-high
//   o_ready      high only while both resets are released
//   o_loss_cnt   saturating count of lock losses after first release

module rst_module #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PERIPH_DELAY       = 16,
    parameter int SW_RST_CYCLES      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    input  logic       i_sw_rst,
    output logic       o_rst_core,
    output logic       o_rst_periph,
    output logic       o_ready,
    output logic [7:0] o_loss_cnt
);

    localparam int MAX_AB  = (LOCK_STABLE_CYCLES > PERIPH_DELAY) ? LOCK_STABLE_CYCLES : PERIPH_DELAY;
    localparam int MAX_CNT = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
    // Counter only has to reach MAX_CNT-1; guard the degenerate all-ones case.
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_STABLE    = 3'd1;
    localparam logic [2:0] S_REL_CORE  = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_SWRST     = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             loss_q, loss_d;
    logic                   lk_s;
    logic                   lost;

    assign lk_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_locked};
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;

        // Lock loss after the core has been released at least once wins over
        // everything else; loss during STABLE is just a failed qualification.
        lost = !lk_s && ((state_q == S_REL_CORE) || (state_q == S_RUN) || (state_q == S_SWRST));

        if (lost) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end
                end
                S_STABLE: begin
                    if (!lk_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = S_REL_CORE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REL_CORE: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (i_sw_rst) begin
                        state_d = S_SWRST;
                        cnt_d   = '0;
                    end
                end
                S_SWRST: begin
                    // Lock is already qualified, so go straight to REL_CORE.
                    if (cnt_q == SW_LAST) begin
                        state_d = S_REL_CORE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= 8'd0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        o_rst_core   = 1'b1;
        o_rst_periph = 1'b1;
        case (state_q)
            S_REL_CORE: begin
                o_rst_core   = 1'b0;
                o_rst_periph = 1'b1;
            end
            S_RUN: begin
                o_rst_core   = 1'b0;
                o_rst_periph = 1'b0;
            end
            default: begin
                o_rst_core   = 1'b1;
                o_rst_periph = 1'b1;
            end
        endcase
    end

    assign o_ready    = (state_q == S_RUN);
    assign o_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_module.sv
// tb/tb_rst_module.sv - self-checking bench for rst_module

module tb_rst_module;

    localparam int SS = 2;
    localparam int LS = 8;
    localparam int PD = 4;
    localparam int SW = 3;

    logic       clk;
    logic       i_rst;
    logic       i_locked;
    logic       i_sw_rst;
    logic       o_rst_core;
    logic       o_rst_periph;
    logic       o_ready;
    logic [7:0] o_loss_cnt;

    int total;
    int bad;

    rst_module #(
        .SYNC_STAGES(SS),
        .LOCK_STABLE_CYCLES(LS),
        .PERIPH_DELAY(PD),
        .SW_RST_CYCLES(SW)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_locked(i_locked),
        .i_sw_rst(i_sw_rst),
        .o_rst_core(o_rst_core),
        .o_rst_periph(o_rst_periph),
        .o_ready(o_ready),
        .o_loss_cnt(o_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timestamps of the planned release edges rather than
    // a state/counter machine. n is the index of the most recent edge.
    int   m_n;
    bit   m_wait;
    int   m_sess_rel;
    int   m_core_rel;
    int   m_periph_rel;
    int   m_loss;
    bit   m_hist[SS];
    bit   m_core;
    bit   m_periph;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input bit s);
        bit lk_pre;
        m_n++;
        lk_pre = m_hist[SS-1];
        if (r) begin
            m_wait = 1'b1;
            m_loss = 0;
            for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
        end else begin
            if (m_wait) begin
                if (lk_pre) begin
                    m_wait       = 1'b0;
                    m_sess_rel   = m_n + LS;
                    m_core_rel   = m_n + LS;
                    m_periph_rel = m_n + LS + PD;
                end
            end else if (!lk_pre) begin
                // Before the session's first core release we are only qualifying.
                if (m_n > m_sess_rel && m_loss < 255) m_loss++;
                m_wait = 1'b1;
            end else if (m_n > m_periph_rel && s) begin
                m_core_rel   = m_n + SW;
                m_periph_rel = m_n + SW + PD;
            end
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = l;
        end
        m_core   = m_wait || (m_n < m_core_rel);
        m_periph = m_wait || (m_n < m_periph_rel);
    endtask

    task automatic step(input bit r, input bit l, input bit s);
        i_rst    = r;
        i_locked = l;
        i_sw_rst = s;
        @(posedge clk);
        model_edge(r, l, s);
        #1;
        chk("model_core", int'(o_rst_core), int'(m_core));
        chk("model_periph", int'(o_rst_periph), int'(m_periph));
        chk("model_ready", int'(o_ready), int'(!m_periph));
        chk("model_loss", int'(o_loss_cnt), m_loss);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // From WAIT_LOCK with lk_s low: hold lock until RUN is reached.
    task automatic bring_up(input string tag);
        for (int k = 1; k <= 15; k++) step(1'b0, 1'b1, 1'b0);
        chk({tag, "_ready"}, int'(o_ready), 1);
    endtask

    typedef struct {
        logic       rst;
        logic       lk;
        logic       sw;
        logic       core;
        logic       periph;
        logic       ready;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[26];

    initial begin
        int exp_loss;
        bit rl;
        bit rs;
        bit rr;

        total = 0;
        bad   = 0;
        m_n = 0; m_wait = 1'b1; m_sess_rel = 0; m_core_rel = 0; m_periph_rel = 0; m_loss = 0;
        m_core = 1'b1; m_periph = 1'b1;
        for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
        i_rst = 1'b1; i_locked = 1'b0; i_sw_rst = 1'b0;

        // Power-up table: 3 reset cycles, then lock from edge k=1.
        for (int i = 0; i < 26; i++) begin
            int k;
            k = i - 2;
            tbl[i].rst    = (i < 3);
            tbl[i].lk     = (i >= 3);
            tbl[i].sw     = 1'b0;
            tbl[i].core   = (i < 3) || (k < 11);
            tbl[i].periph = (i < 3) || (k < 15);
            tbl[i].ready  = !tbl[i].periph;
            tbl[i].loss   = 8'd0;
        end
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rst, tbl[i].lk, tbl[i].sw);
            chk($sformatf("tbl%0d_core", i), int'(o_rst_core), int'(tbl[i].core));
            chk($sformatf("tbl%0d_periph", i), int'(o_rst_periph), int'(tbl[i].periph));
            chk($sformatf("tbl%0d_ready", i), int'(o_ready), int'(tbl[i].ready));
            chk($sformatf("tbl%0d_loss", i), int'(o_loss_cnt), int'(tbl[i].loss));
        end

        // Glitch during qualification.
        do_reset();
        chk("rst_core", int'(o_rst_core), 1);
        chk("rst_ready", int'(o_ready), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("glitch_core_k%0d", k), int'(o_rst_core), (k < 11) ? 1 : 0);
        end
        chk("glitch_loss", int'(o_loss_cnt), 0);

        // Lock loss in RUN then relock.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        chk("loss_pre_ready", int'(o_ready), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_e2_ready", int'(o_ready), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_e3_core", int'(o_rst_core), 1);
        chk("loss_e3_periph", int'(o_rst_periph), 1);
        chk("loss_e3_ready", int'(o_ready), 0);
        chk("loss_e3_cnt", int'(o_loss_cnt), 1);
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("relock_core_k%0d", k), int'(o_rst_core), (k < 11) ? 1 : 0);
            chk($sformatf("relock_ready_k%0d", k), int'(o_ready), (k < 15) ? 0 : 1);
        end

        // One-cycle software reset.
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 1'b1, (j == 1));
            chk($sformatf("sw_core_j%0d", j), int'(o_rst_core), (j <= 3) ? 1 : 0);
            chk($sformatf("sw_periph_j%0d", j), int'(o_rst_periph), (j <= 7) ? 1 : 0);
        end
        chk("sw_loss", int'(o_loss_cnt), 1);

        // sw request on the very cycle lk_s is low in RUN: lock loss wins.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("prio_loss", int'(o_loss_cnt), 2);
        chk("prio_ready", int'(o_ready), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        chk("prio_loss_after", int'(o_loss_cnt), 2);

        // Saturation of the loss counter.
        do_reset();
        for (int e = 1; e <= 260; e++) begin
            bring_up("sat");
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
            exp_loss = (e > 255) ? 255 : e;
            if (e >= 254) chk($sformatf("sat_e%0d", e), int'(o_loss_cnt), exp_loss);
        end
        chk("sat_final", int'(o_loss_cnt), 255);
        step(1'b1, 1'b1, 1'b0);
        chk("sat_rst_loss", int'(o_loss_cnt), 0);
        chk("sat_rst_core", int'(o_rst_core), 1);

        // Randomized run against the reference model.
        rl = 1'b1;
        rs = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) rl = !rl;
            rs = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 599) == 0);
            step(rr, rl, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
